// File: rtl/uart_tx_framer_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   UART_ACC_W   width of the baud phase accumulator
//   UART_DATA_W  character width
//   txState_e    transmitter FSM encoding (StParity exists only with UART_TX_PARITY_EN)
//   baudInc()    accumulator increment round(Baud * 2^UART_ACC_W / ClkFrequency)
// Optional feature macro: UART_TX_PARITY_EN.
package uart_pkg;

   localparam int unsigned UART_ACC_W  = 24;
   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } txState_e;

   function automatic logic [UART_ACC_W-1:0] baudInc(input longint unsigned clkFreq,
                                                     input longint unsigned baud);
      longint unsigned num;
      // Add half the divisor so the integer division rounds to nearest.
      num = (baud << UART_ACC_W) + (clkFreq / 2);
      return UART_ACC_W'(num / clkFreq);
   endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: byte handshake into the UART transmitter.
//   TxD_start  byte-valid strobe (master -> slave)
//   TxD_data   byte to send (master -> slave)
//   TxD_ready  holding register empty (slave -> master)
// A byte transfers on any clock edge where TxD_start && TxD_ready.
interface uart_tx_framer_if;
   import uart_pkg::*;

   logic                   TxD_start;
   logic [UART_DATA_W-1:0] TxD_data;
   logic                   TxD_ready;

   modport master (output TxD_start, output TxD_data, input TxD_ready);
   modport slave  (input TxD_start, input TxD_data, output TxD_ready);

endinterface

// File: rtl/uart_tx_baud_tick.sv
// uart_tx_baud_tick: phase-accumulator bit-rate generator.
//   clk     clock
//   rst_n   asynchronous active-low reset
//   clear   zero the accumulator (takes priority over enable)
//   enable  advance the accumulator this cycle
//   tick    accumulator carry-out; one cycle wide, once per bit period on average
module uart_tx_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned ClkFrequency = 66000000,
   parameter int unsigned Baud         = 9600
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [UART_ACC_W-1:0] Inc = baudInc(ClkFrequency, Baud);

   logic [UART_ACC_W-1:0] acc;
   logic [UART_ACC_W:0]   sum;

   assign sum  = {1'b0, acc} + {1'b0, Inc};
   assign tick = enable & sum[UART_ACC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= sum[UART_ACC_W-1:0];
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: RS-232 byte transmitter with one-byte holding register.
//   clk       sole clock
//   rst_n     asynchronous active-low reset
//   txIf      byte handshake (slave side): TxD_start, TxD_data in; TxD_ready out
//   TxD       serial line, registered, idles high
//   TxD_busy  high while a frame is on the line
// Frame: start, 8 data bits LSB first, [even parity], StopBits stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int unsigned ClkFrequency = 66000000,
   parameter int unsigned Baud         = 9600,
   parameter int unsigned StopBits     = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_framer_if.slave txIf,
   output logic            TxD,
   output logic            TxD_busy
);

   if (ClkFrequency < 2 * Baud) begin : gen_bad_baud
      $error("uart_tx_framer: ClkFrequency must be at least 2*Baud");
   end
   if (StopBits != 1 && StopBits != 2) begin : gen_bad_stop
      $error("uart_tx_framer: StopBits must be 1 or 2");
   end

   localparam logic [2:0] LastStop = 3'(StopBits - 1);

   txState_e               state;
   logic [UART_DATA_W-1:0] hold_data;
   logic                   hold_full;
   logic [UART_DATA_W-1:0] shifter;
   logic [2:0]             bit_cnt;
   logic                   tick;
   logic                   accept;
   logic                   stopDone;
   logic                   load;
`ifdef UART_TX_PARITY_EN
   logic                   parityBit;
`endif

   assign accept         = txIf.TxD_start & ~hold_full;
   assign stopDone       = (state == StStop) & tick & (bit_cnt == LastStop);
   // Load from idle, or straight out of the last stop bit for back-to-back frames.
   assign load           = hold_full & ((state == StIdle) | stopDone);
   assign txIf.TxD_ready = ~hold_full;

   uart_tx_baud_tick #(
      .ClkFrequency (ClkFrequency),
      .Baud         (Baud)
   ) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (load),
      .enable (state != StIdle),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else begin
         if (accept) hold_data <= txIf.TxD_data;
         hold_full <= accept | (hold_full & ~load);
      end
   end

   // TxD/TxD_busy are assigned alongside each transition so they track the
   // state being entered and come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         shifter   <= '0;
         bit_cnt   <= '0;
         TxD       <= 1'b1;
         TxD_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else if (load) begin
         state     <= StStart;
         shifter   <= hold_data;
         bit_cnt   <= '0;
         TxD       <= 1'b0;
         TxD_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parityBit <= ^hold_data;
`endif
      end else if (tick) begin
         case (state)
            StStart: begin
               state <= StData;
               TxD   <= shifter[0];
            end
            StData: begin
               shifter <= shifter >> 1;
               if (bit_cnt == 3'd7) begin
                  bit_cnt <= '0;  // reused as the stop-bit counter
`ifdef UART_TX_PARITY_EN
                  state   <= StParity;
                  TxD     <= parityBit;
`else
                  state   <= StStop;
                  TxD     <= 1'b1;
`endif
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  TxD     <= shifter[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               state <= StStop;
               TxD   <= 1'b1;
            end
`endif
            StStop: begin
               if (bit_cnt == LastStop) begin
                  state    <= StIdle;
                  bit_cnt  <= '0;
                  TxD      <= 1'b1;
                  TxD_busy <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: self-checking bench for uart_tx_framer at 10 clocks per bit.
// A line monitor decodes every frame against a scoreboard of accepted bytes; a
// vector table plus hand sequences cover latency, back-to-back, overrun, reset
// and a StopBits=1 instance.
module tb_uart_tx_framer;
   import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int BitCyc   = 10;
   localparam int NBits    = 1 + 8 + P + 2;
   localparam int FrameCyc = NBits * BitCyc;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } sb_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         busyCyc;
   } vec_t;

   logic clk;
   logic rst_n;
   logic TxD, TxD_busy, TxD1, TxD_busy1;
   int   cyc;
   int   nChecks;
   int   nErrors;
   sb_t  sbq[$];

   uart_tx_framer_if txIf ();
   uart_tx_framer_if txIf1 ();

   uart_tx_framer #(.ClkFrequency(1000000), .Baud(100000), .StopBits(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .txIf     (txIf),
      .TxD      (TxD),
      .TxD_busy (TxD_busy)
   );

   uart_tx_framer #(.ClkFrequency(1000000), .Baud(100000), .StopBits(1)) dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .txIf     (txIf1),
      .TxD      (TxD1),
      .TxD_busy (TxD_busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic expBit(input sb_t s, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return s.data[i-1];
      if (P == 1 && i == 9) return s.par;
      return 1'b1;
   endfunction

   // Offer a byte and hold TxD_start until accepted; returns the accept cycle.
   task automatic send(input logic [7:0] b, input logic par, output int acc);
      int n;
      n = 0;
      acc = -1;
      txIf.TxD_start = 1'b1;
      txIf.TxD_data  = b;
      while (txIf.TxD_ready !== 1'b1 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 2000) begin
         checkEq("send ready timeout", 32'(n), 32'(0));
         txIf.TxD_start = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         sbq.push_back('{b, par});
         txIf.TxD_start = 1'b0;
         txIf.TxD_data  = ~b;  // must be ignored from here on
      end
   endtask

   task automatic countBusy(output int c);
      c = 0;
      while (TxD_busy === 1'b1 && c < 5000) begin
         @(posedge clk);
         #1;
         c++;
      end
   endtask

   // Line monitor
   bit  monActive;
   int  monIdx, monInBit, monOnes, monBusy;
   sb_t monCur;

   initial begin
      monActive = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            monActive = 1'b0;
            sbq.delete();
         end else begin
            if (!monActive && TxD === 1'b0) begin
               if (sbq.size() == 0) begin
                  checkEq("unexpected start bit", 32'(TxD), 32'(1));
               end else begin
                  monCur    = sbq.pop_front();
                  monActive = 1'b1;
                  monIdx    = 0;
                  monInBit  = 0;
                  monOnes   = 0;
                  monBusy   = 0;
               end
            end
            if (monActive) begin
               monOnes += (TxD === 1'b1) ? 1 : 0;
               monBusy += (TxD_busy === 1'b1) ? 1 : 0;
               monInBit++;
               if (monInBit == BitCyc) begin
                  checkEq($sformatf("byte %02h bit %0d high cycles", monCur.data, monIdx),
                          32'(monOnes), expBit(monCur, monIdx) ? 32'(BitCyc) : 32'(0));
                  monIdx++;
                  monInBit = 0;
                  monOnes  = 0;
                  if (monIdx == NBits) begin
                     checkEq($sformatf("byte %02h busy within frame", monCur.data),
                             32'(monBusy), 32'(FrameCyc));
                     monActive = 1'b0;
                  end
               end
            end
         end
      end
   end

   vec_t vecs[5];
   logic s1[0:255];

   initial begin
      int a1, a2, a3, c, t;
      nChecks = 0;
      nErrors = 0;
      cyc     = 0;
      txIf.TxD_start  = 1'b0;
      txIf.TxD_data   = 8'h00;
      txIf1.TxD_start = 1'b0;
      txIf1.TxD_data  = 8'h00;

      vecs[0] = '{8'hA5, 1'b0, FrameCyc};
      vecs[1] = '{8'h07, 1'b1, FrameCyc};
      vecs[2] = '{8'h03, 1'b0, FrameCyc};
      vecs[3] = '{8'h80, 1'b1, FrameCyc};
      vecs[4] = '{8'h3C, 1'b0, FrameCyc};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkEq("reset TxD", 32'(TxD), 32'(1));
      checkEq("reset TxD_busy", 32'(TxD_busy), 32'(0));
      checkEq("reset TxD_ready", 32'(txIf.TxD_ready), 32'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single frames: accept latency, start-bit timing and frame length
      for (int i = 0; i < 5; i++) begin
         send(vecs[i].data, vecs[i].par, a1);
         checkEq("ready low after accept", 32'(txIf.TxD_ready), 32'(0));
         checkEq("TxD high before load", 32'(TxD), 32'(1));
         @(posedge clk);
         #1;
         checkEq("start bit after load", 32'(TxD), 32'(0));
         checkEq("busy after load", 32'(TxD_busy), 32'(1));
         checkEq("ready after load", 32'(txIf.TxD_ready), 32'(1));
         countBusy(c);
         checkEq($sformatf("vec %0d busy cycles", i), 32'(c), 32'(vecs[i].busyCyc));
         repeat (3) @(posedge clk);
         #1;
      end

      // Back-to-back 0x00 then 0xFF
      send(8'h00, 1'b0, a1);
      fork
         send(8'hFF, 1'b0, a2);
         begin
            @(posedge clk);
            #1;
            countBusy(c);
         end
      join
      checkEq("b2b second accept offset", 32'(a2 - a1), 32'(2));
      checkEq("b2b busy cycles", 32'(c), 32'(2 * FrameCyc));
      repeat (3) @(posedge clk);
      #1;

      // Overrun: three bytes offered with TxD_start held high
      send(8'h12, 1'b0, a1);
      fork
         begin
            send(8'h34, 1'b1, a2);
            send(8'h56, 1'b0, a3);
         end
         begin
            @(posedge clk);
            #1;
            countBusy(c);
         end
      join
      checkEq("overrun 2nd accept offset", 32'(a2 - a1), 32'(2));
      checkEq("overrun 3rd accept offset", 32'(a3 - a1), 32'(2 + FrameCyc));
      checkEq("overrun busy cycles", 32'(c), 32'(3 * FrameCyc));
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-frame
      send(8'hC3, 1'b0, a1);
      repeat (35) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkEq("mid-frame reset TxD", 32'(TxD), 32'(1));
      checkEq("mid-frame reset busy", 32'(TxD_busy), 32'(0));
      checkEq("mid-frame reset ready", 32'(txIf.TxD_ready), 32'(1));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (TxD === 1'b1 && TxD_busy === 1'b0) t++;
      end
      checkEq("quiet cycles after reset", 32'(t), 32'(50));

      // StopBits=1 instance, byte 0x55
      txIf1.TxD_start = 1'b1;
      txIf1.TxD_data  = 8'h55;
      @(posedge clk);
      #1;
      txIf1.TxD_start = 1'b0;
      txIf1.TxD_data  = 8'hFF;
      @(posedge clk);
      #1;
      c = 0;
      while (TxD_busy1 === 1'b1 && c < 256) begin
         s1[c] = TxD1;
         c++;
         @(posedge clk);
         #1;
      end
      checkEq("stop1 busy cycles", 32'(c), 32'(BitCyc * (10 + P)));
      t = 0;
      for (int j = c - 1; j >= 0; j--) begin
         if (s1[j] !== 1'b1) break;
         t++;
      end
      checkEq("stop1 stop phase cycles", 32'(t), 32'(BitCyc));
      checkEq("stop1 start bit", 32'(s1[0]), 32'(0));

      repeat (5) @(posedge clk);
      #1;
      checkEq("scoreboard drained", 32'(sbq.size()), 32'(0));
      checkEq("monitor idle at end", 32'(monActive), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
